// File: rtl/bldc_spin_ctrl.sv
// Six-step BLDC spin-up and speed sequencer: alignment, open-loop ramp, then
// closed-loop duty regulation against a target commutation period.
module bldc_spin_ctrl #(
  parameter int unsigned TICK_DIV     = 16,
  parameter int unsigned ALIGN_TICKS  = 20000,
  parameter int unsigned RAMP_START   = 5000,
  parameter int unsigned RAMP_MIN     = 200,
  parameter int unsigned RAMP_STEP    = 25,
  parameter int unsigned START_DUTY   = 25,
  parameter int unsigned RUN_DUTY_MIN = 50,
  parameter int unsigned STALL_TICKS  = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] target_period,
  input  logic        comm_evt,
  input  logic        fault_clr,
  output logic [2:0]  step,
  output logic [7:0]  duty,
  output logic        drive_en,
  output logic [2:0]  state,
  output logic [15:0] meas_period,
  output logic        stall
);

  localparam int unsigned PW             = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RUN_ENTRY_DUTY = (START_DUTY > RUN_DUTY_MIN) ? START_DUTY : RUN_DUTY_MIN;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [15:0]   ALIGN_LOAD  = 16'(ALIGN_TICKS);
  localparam logic [15:0]   RAMP_LOAD   = 16'(RAMP_START);
  localparam logic [15:0]   RAMP_DEC    = 16'(RAMP_STEP);
  localparam logic [15:0]   RAMP_THR    = 16'(RAMP_MIN + RAMP_STEP);
  localparam logic [15:0]   STALL_LIM   = 16'(STALL_TICKS);
  localparam logic [7:0]    DUTY_START  = 8'(START_DUTY);
  localparam logic [7:0]    DUTY_FLOOR  = 8'(RUN_DUTY_MIN);
  localparam logic [7:0]    DUTY_ENTRY  = 8'(RUN_ENTRY_DUTY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      st;
  logic [PW-1:0] presc;
  logic [15:0] timer;
  logic [15:0] wait_r;
  logic [15:0] per_cnt;
  logic        tick;
  logic        expire;
  logic [2:0]  step_nxt;

  assign tick     = (presc == PRESC_LAST);
  assign expire   = tick && (timer == 16'd1);
  assign step_nxt = (step == 3'd5) ? 3'd0 : step + 3'd1;
  assign state    = st;

  // Free-running timing-tick prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Sequencer FSM with registered outputs, interval timer and period counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      step        <= 3'd0;
      duty        <= 8'd0;
      drive_en    <= 1'b0;
      meas_period <= 16'd0;
      stall       <= 1'b0;
      timer       <= 16'd0;
      wait_r      <= 16'd0;
      per_cnt     <= 16'd0;
    end else begin
      if (tick && (timer != 16'd0)) timer <= timer - 16'd1;

      // Dropping enable aborts any active phase and beats same-cycle events
      if ((st inside {S_ALIGN, S_RAMP, S_RUN}) && !enable) begin
        st       <= S_IDLE;
        step     <= 3'd0;
        duty     <= 8'd0;
        drive_en <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            step     <= 3'd0;
            duty     <= 8'd0;
            drive_en <= 1'b0;
            stall    <= 1'b0;
            if (enable) begin
              st       <= S_ALIGN;
              timer    <= ALIGN_LOAD;
              duty     <= DUTY_START;
              drive_en <= 1'b1;
            end
          end
          S_ALIGN: begin
            if (expire) begin
              st     <= S_RAMP;
              timer  <= RAMP_LOAD;
              wait_r <= RAMP_LOAD;
            end
          end
          S_RAMP: begin
            if (expire) begin
              step <= step_nxt;
              if (wait_r < RAMP_THR) begin
                st      <= S_RUN;
                duty    <= DUTY_ENTRY;
                per_cnt <= 16'd0;
              end else begin
                wait_r <= wait_r - RAMP_DEC;
                timer  <= wait_r - RAMP_DEC;
              end
            end
          end
          S_RUN: begin
            // A commutation event takes precedence over both the tick and the stall limit
            if (comm_evt) begin
              step        <= step_nxt;
              meas_period <= per_cnt;
              per_cnt     <= 16'd0;
              if (per_cnt > target_period) begin
                if (duty != 8'hFF) duty <= duty + 8'd1;
              end else if (per_cnt < target_period) begin
                duty <= (duty > DUTY_FLOOR) ? duty - 8'd1 : DUTY_FLOOR;
              end
            end else if (per_cnt >= STALL_LIM) begin
              st       <= S_FAULT;
              duty     <= 8'd0;
              drive_en <= 1'b0;
              stall    <= 1'b1;
            end else if (tick && (per_cnt != 16'hFFFF)) begin
              per_cnt <= per_cnt + 16'd1;
            end
          end
          S_FAULT: begin
            if (fault_clr) begin
              st    <= S_IDLE;
              step  <= 3'd0;
              stall <= 1'b0;
            end
          end
          default: begin
            st       <= S_IDLE;
            step     <= 3'd0;
            duty     <= 8'd0;
            drive_en <= 1'b0;
            stall    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bldc_spin_ctrl.sv
// Scoreboard bench for bldc_spin_ctrl: a tick-counting reference model predicts
// every cycle's outputs and a separate monitor compares them against the DUT.
module tb_bldc_spin_ctrl;

  localparam int TD     = 2;
  localparam int AT     = 4;
  localparam int RS     = 10;
  localparam int RMIN   = 4;
  localparam int RSTEP  = 3;
  localparam int STALLT = 40;
  localparam int SD     = 25;
  localparam int RDMIN  = 50;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] target_period;
  logic        comm_evt;
  logic        fault_clr;
  logic [2:0]  step;
  logic [7:0]  duty;
  logic        drive_en;
  logic [2:0]  state;
  logic [15:0] meas_period;
  logic        stall;

  bldc_spin_ctrl #(
    .TICK_DIV(TD), .ALIGN_TICKS(AT), .RAMP_START(RS), .RAMP_MIN(RMIN),
    .RAMP_STEP(RSTEP), .START_DUTY(SD), .RUN_DUTY_MIN(RDMIN), .STALL_TICKS(STALLT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .target_period(target_period),
    .comm_evt(comm_evt), .fault_clr(fault_clr), .step(step), .duty(duty),
    .drive_en(drive_en), .state(state), .meas_period(meas_period), .stall(stall)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  stp;
    logic [7:0]  dty;
    logic        drv;
    logic [15:0] meas;
    logic        stl;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: time is kept as absolute edge and tick counts
  int     m_st, m_step, m_duty, m_drv, m_meas, m_stall, m_wait;
  longint m_edge, m_ticks, m_deadline, m_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_st = 0; m_step = 0; m_duty = 0; m_drv = 0; m_meas = 0; m_stall = 0; m_wait = 0;
    m_edge = 0; m_ticks = 0; m_deadline = -1; m_clr = 0;
  endfunction

  function automatic void model_idle();
    m_st = 0; m_step = 0; m_duty = 0; m_drv = 0; m_stall = 0;
  endfunction

  function automatic void model_edge(input bit en, input int tp, input bit ce, input bit fc);
    bit     t;
    bit     expd;
    longint cnt;
    t   = (m_edge % TD) == (TD - 1);
    cnt = m_ticks - m_clr;
    if (cnt > 65535) cnt = 65535;
    if (t) m_ticks++;
    expd = t && (m_ticks == m_deadline);
    m_edge++;
    if (m_st inside {1, 2, 3} && !en) begin
      model_idle();
    end else begin
      case (m_st)
        0: if (en) begin
          m_st = 1; m_drv = 1; m_duty = SD; m_step = 0; m_deadline = m_ticks + AT;
        end
        1: if (expd) begin
          m_st = 2; m_wait = RS; m_deadline = m_ticks + RS;
        end
        2: if (expd) begin
          m_step = (m_step + 1) % 6;
          if (m_wait < RMIN + RSTEP) begin
            m_st = 3; m_duty = (SD > RDMIN) ? SD : RDMIN; m_clr = m_ticks;
          end else begin
            m_wait = m_wait - RSTEP; m_deadline = m_ticks + m_wait;
          end
        end
        3: if (ce) begin
          m_step = (m_step + 1) % 6;
          m_meas = int'(cnt);
          m_clr  = m_ticks;
          if (cnt > tp) m_duty = (m_duty == 255) ? 255 : m_duty + 1;
          else if (cnt < tp) m_duty = (m_duty - 1 < RDMIN) ? RDMIN : m_duty - 1;
        end else if (cnt >= STALLT) begin
          m_st = 4; m_drv = 0; m_duty = 0; m_stall = 1;
        end
        4: if (fc) model_idle();
        default: model_idle();
      endcase
    end
  endfunction

  // Called at a negedge: apply inputs, predict the post-posedge outputs, advance
  task automatic cyc(input bit en, input bit ce, input bit fc);
    obs_t e;
    enable = en; comm_evt = ce; fault_clr = fc;
    model_edge(en, int'(target_period), ce, fc);
    e.st = 3'(m_st); e.stp = 3'(m_step); e.dty = 8'(m_duty); e.drv = 1'(m_drv);
    e.meas = 16'(m_meas); e.stl = 1'(m_stall);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic spot(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic comm_every(input int n_ev, input int gap);
    repeat (n_ev) begin
      cyc(1'b1, 1'b1, 1'b0);
      repeat (gap - 1) cyc(1'b1, 1'b0, 1'b0);
    end
  endtask

  // Put the next edge on a non-tick phase so period measurements are exact
  task automatic align_even();
    if ((m_edge % TD) != 0) cyc(1'b1, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin : monitor
    obs_t e;
    obs_t a;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state, step, duty, drive_en, meas_period, stall};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t act st=%0d step=%0d duty=%0d drv=%0d meas=%0d stall=%0d req st=%0d step=%0d duty=%0d drv=%0d meas=%0d stall=%0d",
                 $time, a.st, a.stp, a.dty, a.drv, a.meas, a.stl, e.st, e.stp, e.dty, e.drv, e.meas, e.stl);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int  guard;
    int  off;
    bit  en;
    bit  ce;
    bit  fc;
    reset_n = 1'b0; enable = 1'b0; comm_evt = 1'b0; fault_clr = 1'b0; target_period = 16'd10;
    model_reset();
    #7;
    spot("reset_state", int'(state), 0);
    spot("reset_step", int'(step), 0);
    spot("reset_duty", int'(duty), 0);
    spot("reset_drive", int'(drive_en), 0);
    spot("reset_meas", int'(meas_period), 0);
    spot("reset_stall", int'(stall), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Start-up through alignment and ramp
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (60) cyc(1'b1, 1'b0, 1'b0);
    spot("startup_state", int'(state), 3);
    spot("startup_step", int'(step), 3);
    spot("startup_duty", int'(duty), 50);
    spot("startup_drive", int'(drive_en), 1);

    // Closed loop, slow rotation raises duty
    target_period = 16'd10;
    align_even();
    comm_every(6, 30);
    spot("slow_meas", int'(meas_period), 15);
    spot("slow_duty", int'(duty), 55);
    spot("slow_step", int'(step), 3);

    // Equal period holds duty (after one slow measurement bumps it)
    target_period = 16'd5;
    comm_every(6, 10);
    spot("hold_duty", int'(duty), 56);
    spot("hold_meas", int'(meas_period), 5);

    // Fast rotation pulls duty down to the floor
    target_period = 16'd10;
    comm_every(12, 10);
    spot("floor_duty", int'(duty), 50);

    // Commutation event exactly at the stall limit wins
    guard = 0;
    while (((m_ticks - m_clr) != STALLT) && (guard < 200)) begin
      cyc(1'b1, 1'b0, 1'b0);
      guard++;
    end
    spot("stall_edge_reached", (guard < 200) ? 1 : 0, 1);
    cyc(1'b1, 1'b1, 1'b0);
    spot("stall_edge_state", int'(state), 3);
    spot("stall_edge_meas", int'(meas_period), STALLT);

    // Stall into FAULT, enable ignored, fault_clr returns to IDLE
    repeat (100) cyc(1'b1, 1'b0, 1'b0);
    spot("fault_state", int'(state), 4);
    spot("fault_stall", int'(stall), 1);
    spot("fault_duty", int'(duty), 0);
    spot("fault_drive", int'(drive_en), 0);
    for (int i = 0; i < 10; i++) cyc(1'(i % 2), 1'b0, 1'b0);
    spot("fault_enable_ignored", int'(state), 4);
    cyc(1'b0, 1'b0, 1'b1);
    spot("fault_clr_state", int'(state), 0);
    spot("fault_clr_stall", int'(stall), 0);

    // Abort in RUN together with a commutation event
    repeat (60) cyc(1'b1, 1'b0, 1'b0);
    comm_every(3, 8);
    cyc(1'b0, 1'b1, 1'b0);
    spot("abort_state", int'(state), 0);
    spot("abort_step", int'(step), 0);

    // Randomized closed-loop operation with stray fault_clr pulses
    repeat (60) cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      target_period = 16'($urandom_range(3, 25));
      cyc(1'b1, 1'b1, 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(1, 59)) cyc(1'b1, 1'b0, 1'($urandom_range(0, 15) == 0));
    end

    // Random enable drops during alignment and ramp
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 60)) cyc(1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(1, 5)) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset in the middle of the ramp
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (20) cyc(1'b1, 1'b0, 1'b0);
    spot("pre_reset_state", int'(state), 2);
    #2;
    reset_n = 1'b0;
    #1;
    spot("async_state", int'(state), 0);
    spot("async_step", int'(step), 0);
    spot("async_duty", int'(duty), 0);
    spot("async_drive", int'(drive_en), 0);
    spot("async_meas", int'(meas_period), 0);
    spot("async_stall", int'(stall), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    spot("restart_state", int'(state), 1);
    spot("restart_duty", int'(duty), 25);

    // Random soak
    off = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((off == 0) && ($urandom_range(0, 399) == 0)) off = $urandom_range(1, 4);
      en = (off == 0);
      if (off > 0) off--;
      ce = ($urandom_range(0, 9) == 0);
      fc = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) target_period = 16'($urandom_range(1, 20));
      cyc(en, ce, fc);
    end

    @(negedge clk);
    spot("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bldc_spin_ctrl.md
# bldc_spin_ctrl

Spin-up and speed sequencer for the three-phase six-step motor driver. It runs the rotor through alignment and an open-loop commutation ramp, then hands commutation to debounced feedback events. In closed loop it regulates the 8-bit PWM duty so that the measured per-step period tracks a software target. It sits between the XLR8 register interface and the phase driver/PWM datapath, supplying `step`, `duty` and `drive_en`.

## Interface
Parameters:
- `TICK_DIV`, 16: clk cycles per timing tick (1 µs at 16 MHz).
- `ALIGN_TICKS`, 20000: alignment hold time, in ticks.
- `RAMP_START`, 5000: first open-loop step period, in ticks.
- `RAMP_MIN`, 200: shortest open-loop step period, in ticks.
- `RAMP_STEP`, 25: per-step period decrement during ramp, in ticks.
- `START_DUTY`, 25: duty during ALIGN and RAMP.
- `RUN_DUTY_MIN`, 50: duty floor in RUN.
- `STALL_TICKS`, 50000: RUN-state commutation timeout, in ticks.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous active-low reset.
- `enable` input 1: level; request motor spinning.
- `target_period` input 16: desired ticks per commutation step in RUN.
- `comm_evt` input 1: single-cycle pulse, debounced feedback edge.
- `fault_clr` input 1: single-cycle pulse, leave FAULT.
- `step` output 3: commutation step, 0..5.
- `duty` output 8: PWM compare value.
- `drive_en` output 1: phase drivers enabled.
- `state` output 3: IDLE=0, ALIGN=1, RAMP=2, RUN=3, FAULT=4.
- `meas_period` output 16: last measured RUN step period, in ticks.
- `stall` output 1: high while in FAULT.

## Operation
- Tick prescaler: counter runs 0..TICK_DIV-1 and wraps. `tick` is high for one cycle on the wrap. It free-runs from reset.
- Interval timer (16-bit): loaded with N and decremented on each tick. It expires on the tick where the value is 1, so an interval is exactly N ticks.
- IDLE: `drive_en`=0, `duty`=0, `step`=0. If `enable`=1, go to ALIGN and load ALIGN_TICKS.
- ALIGN: `drive_en`=1, `step`=0, `duty`=START_DUTY. On expiry, go to RAMP and load RAMP_START; `wait` reg=RAMP_START.
- RAMP: `comm_evt` is ignored. On each expiry, `step` advances (5 wraps to 0).
  - If `wait` < RAMP_MIN+RAMP_STEP: go to RUN.
  - Otherwise: `wait` <= `wait`-RAMP_STEP and the timer reloads with the new value.
- RUN entry:
  - `duty` <= max(START_DUTY, RUN_DUTY_MIN).
  - Period counter cleared.
- RUN, period counter: increments on each tick and saturates at 0xFFFF.
- RUN, on `comm_evt`:
  - `step` advances (wrap 5 to 0).
  - `meas_period` <= counter; counter <= 0.
  - Duty update: if counter > `target_period`, `duty`+1, saturating at 255. If counter < `target_period`, `duty`-1, floor RUN_DUTY_MIN. If equal, hold.
- RUN, stall: counter reaching STALL_TICKS goes to FAULT.
- FAULT: `drive_en`=0, `duty`=0, `stall`=1, `step` held. `fault_clr` goes to IDLE; `enable` is ignored.
- `enable`=0 in ALIGN/RAMP/RUN: go to IDLE next cycle. `meas_period` is retained.

## Timing
- Reset values: `step`=0, `duty`=0, `drive_en`=0, `state`=IDLE, `meas_period`=0, `stall`=0. Prescaler, timer, `wait` and period counter are all 0.
- All outputs are registered. State, step and duty change in the cycle after the causing event: `tick`, `comm_evt` or `enable` edge.
- `comm_evt` and `tick` in the same cycle: counter <= 0 and the tick is not counted. The measurement uses the pre-tick counter value.
- `comm_evt` in the same cycle the counter hits STALL_TICKS: the event wins, with no FAULT.
- `enable` falling in the same cycle as a `comm_evt` or expiry: IDLE wins, with no step advance.
- `fault_clr` outside FAULT: no effect.
- `target_period` is sampled only on `comm_evt`; it may change at any time.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). Operation resumes from IDLE on the first clk edge after deassertion.

## Test plan
Overrides for all scenarios: TICK_DIV=2, ALIGN_TICKS=4, RAMP_START=10, RAMP_MIN=4, RAMP_STEP=3, STALL_TICKS=40.
- Start-up: reset, then `enable`=1 -> ALIGN for 8 clk, `duty`=25, `drive_en`=1. RAMP step intervals are 20, 14, 8 clk with `step` 0→1→2→3. RUN is entered with `step`=3, `duty`=50.
- Closed loop: `target_period`=10, `comm_evt` every 30 clk (15 ticks) -> `meas_period`=15, `duty` 51, 52, 53, and `step` wraps 5→0.
- Fast rotation: `comm_evt` every 10 clk with `target_period`=10 -> `duty` stays at 50 (floor). With `target_period`=5, `duty` holds.
- Stall: RUN with no `comm_evt` for 80 clk -> `state`=FAULT, `stall`=1, `duty`=0, `drive_en`=0. Raising `enable` has no effect; `fault_clr` gives IDLE.
- Abort and simultaneity: drop `enable` the same cycle as a `comm_evt` in RUN -> IDLE with `step`=0 next cycle. `comm_evt` exactly at counter=40 -> no FAULT.
- Async reset asserted mid-RAMP -> all outputs zero with no clock edge. After release with `enable`=1, the sequence restarts at ALIGN.
